// File: rtl/huffman_bit_packer_ctrl_if.sv
// huffman_bit_packer_ctrl_if
// Groups the code-input and word-output handshakes of the Huffman bit packer.
//   Code side : in_valid/in_ready/in_data[31:0]/in_len[5:0]/in_last
//   Word side : out_valid/out_ready/out_data[127:0]/out_bits[7:0]/out_last
//   Status    : total_bits[31:0] (running count of accepted code bits)
// The "slave" modport is the packer itself. The "master" modport is its
// environment, which drives the codes and accepts the output words.
interface huffman_bit_packer_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [5:0]   in_len;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_bits;
  logic         out_last;
  logic [31:0]  total_bits;

  modport slave (
    input  in_valid, in_data, in_len, in_last, out_ready,
    output in_ready, out_valid, out_data, out_bits, out_last, total_bits
  );

  modport master (
    output in_valid, in_data, in_len, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_bits, out_last, total_bits
  );
endinterface

// File: rtl/huffman_bit_packer_ctrl.sv
// huffman_bit_packer_ctrl
// Packs variable-length codes (0..32 bits, LSB first) into a 256-bit window
// and emits 128-bit words. A code marked in_last switches the block to
// FLUSH. In FLUSH, the remaining full words drain first. Then one final
// partial word is emitted with its bit count and out_last set.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - slave side of huffman_bit_packer_ctrl_if (code input, word output,
//           total_bits status)
// All outputs decode registered state only, so no input reaches an output
// combinationally.
module huffman_bit_packer_ctrl (
  input  logic                      clk,
  input  logic                      reset,
  huffman_bit_packer_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [255:0] acc_q, acc_d;
  logic [7:0]   fill_q, fill_d;
  logic [31:0]  total_q, total_d;

  logic         tail_s;       // final partial word is being presented
  logic [5:0]   len_s;
  logic [31:0]  code_s;
  logic         push_s;
  logic         pop_s;
  logic [255:0] base_acc_s;   // window after any full-word pop
  logic [7:0]   base_fill_s;

  // Output decode from registered state
  assign tail_s         = (state_q == ST_FLUSH) && (fill_q < 8'd128);
  assign bus.in_ready   = (state_q == ST_RUN) && (fill_q <= 8'd223);
  assign bus.out_valid  = (fill_q >= 8'd128) || (state_q == ST_FLUSH);
  assign bus.out_bits   = tail_s ? fill_q : 8'd128;
  assign bus.out_last   = tail_s;
  assign bus.out_data   = acc_q[127:0];
  assign bus.total_bits = total_q;

  assign push_s = bus.in_valid && bus.in_ready;
  assign pop_s  = bus.out_valid && bus.out_ready;

  // Length clamp and code masking, so bits above fill stay zero
  always_comb begin
    len_s = 6'd0;
    if (bus.in_len > 6'd32) begin
      len_s = 6'd32;
    end else begin
      len_s = bus.in_len;
    end
    // A shift by 32 yields 0, so len 32 gives an all-ones mask
    code_s = bus.in_data & ~(32'hFFFF_FFFF << len_s);
  end

  // Next-state for FSM, window, fill and running bit count
  always_comb begin
    base_acc_s  = acc_q;
    base_fill_s = fill_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    total_d     = total_q;
    state_d     = state_q;

    // A full-word pop shifts the window before the new code is placed, so
    // the code lands at (fill - 128) when both happen in one cycle.
    if (pop_s && !tail_s) begin
      base_acc_s  = acc_q >> 128;
      base_fill_s = fill_q - 8'd128;
    end else begin
      base_acc_s  = acc_q;
      base_fill_s = fill_q;
    end

    acc_d  = base_acc_s;
    fill_d = base_fill_s;

    if (push_s) begin
      acc_d   = base_acc_s | ({224'd0, code_s} << base_fill_s);
      fill_d  = base_fill_s + {2'b00, len_s};
      total_d = total_q + {26'd0, len_s};
    end else begin
      total_d = total_q;
    end

    case (state_q)
      ST_RUN: begin
        if (push_s && bus.in_last) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // No push can happen in FLUSH, so the last pop simply clears everything
        if (pop_s && tail_s) begin
          acc_d   = 256'd0;
          fill_d  = 8'd0;
          total_d = 32'd0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      acc_q   <= 256'd0;
      fill_q  <= 8'd0;
      total_q <= 32'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      total_q <= total_d;
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer_ctrl.sv
// Directed self-checking bench for huffman_bit_packer_ctrl.
module tb_huffman_bit_packer_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  huffman_bit_packer_ctrl_if bus ();

  huffman_bit_packer_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one code for exactly one clock edge, then sample 1 time unit later
  task automatic push(input logic [31:0] d, input logic [5:0] l, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_len   = l;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d [0:7];

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 8; i++) d[i] = 32'hC0DE_0000 + i;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_len    = 6'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_bits", bus.out_bits, 128);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_total", bus.total_bits, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Test 1: four full 32-bit codes make one all-ones word
    for (int i = 0; i < 3; i++) push(32'hFFFF_FFFF, 6'd32, 1'b0);
    chk("t1_no_valid_yet", bus.out_valid, 0);
    push(32'hFFFF_FFFF, 6'd32, 1'b0);
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_out_data", bus.out_data, {128'd0, {128{1'b1}}});
    chk("t1_out_bits", bus.out_bits, 128);
    chk("t1_out_last", bus.out_last, 0);
    bus.out_ready = 1'b1;
    idle_cycle();
    bus.out_ready = 1'b0;
    chk("t1_fill", dut.fill_q, 0);
    chk("t1_total", bus.total_bits, 128);
    chk("t1_valid_after_pop", bus.out_valid, 0);

    // Test 2: 0x5/3, 0x0/0, 0x1/1 last -> final word 0xD with 4 bits
    push(32'h5, 6'd3, 1'b0);
    push(32'h0, 6'd0, 1'b0);
    push(32'h1, 6'd1, 1'b1);
    chk("t2_out_valid", bus.out_valid, 1);
    chk("t2_out_data", bus.out_data, 256'hD);
    chk("t2_out_bits", bus.out_bits, 4);
    chk("t2_out_last", bus.out_last, 1);
    chk("t2_in_ready", bus.in_ready, 0);
    chk("t2_total_pre", bus.total_bits, 132);
    bus.out_ready = 1'b1;
    idle_cycle();
    bus.out_ready = 1'b0;
    chk("t2_total_post", bus.total_bits, 0);
    chk("t2_run_in_ready", bus.in_ready, 1);
    chk("t2_run_valid", bus.out_valid, 0);
    chk("t2_run_bits", bus.out_bits, 128);

    // Test 3: backpressure while streaming 32-bit codes
    for (int i = 0; i < 4; i++) push(d[i], 6'd32, 1'b0);
    chk("t3_word0", bus.out_data, {128'd0, d[3], d[2], d[1], d[0]});
    chk("t3_ready_mid", bus.in_ready, 1);
    for (int i = 4; i < 7; i++) push(d[i], 6'd32, 1'b0);
    chk("t3_fill224", dut.fill_q, 224);
    chk("t3_ready_drop", bus.in_ready, 0);
    chk("t3_hold_data", bus.out_data, {128'd0, d[3], d[2], d[1], d[0]});
    push(d[7], 6'd32, 1'b0);
    chk("t3_refused_fill", dut.fill_q, 224);
    chk("t3_hold_data2", bus.out_data, {128'd0, d[3], d[2], d[1], d[0]});
    chk("t3_hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    idle_cycle();
    bus.out_ready = 1'b0;
    chk("t3_fill96", dut.fill_q, 96);
    chk("t3_ready_back", bus.in_ready, 1);
    chk("t3_residue", bus.out_data, {160'd0, d[6], d[5], d[4]});

    // Test 4: fill 130, simultaneous 0x3/2 push and pop -> fill 4, acc 0xC
    push(d[7], 6'd32, 1'b0);
    push(32'h0, 6'd2, 1'b0);
    chk("t4_fill130", dut.fill_q, 130);
    chk("t4_word1", bus.out_data, {128'd0, d[7], d[6], d[5], d[4]});
    bus.out_ready = 1'b1;
    push(32'h3, 6'd2, 1'b0);
    bus.out_ready = 1'b0;
    chk("t4_fill4", dut.fill_q, 4);
    chk("t4_acc", dut.acc_q, 256'hC);
    push(32'h0, 6'd0, 1'b1);
    chk("t4_tail_bits", bus.out_bits, 4);
    chk("t4_tail_data", bus.out_data, 256'hC);
    bus.out_ready = 1'b1;
    idle_cycle();
    bus.out_ready = 1'b0;

    // Test 5: zero-length last code on an empty window
    push(32'hFFFF_FFFF, 6'd0, 1'b1);
    chk("t5_out_valid", bus.out_valid, 1);
    chk("t5_out_bits", bus.out_bits, 0);
    chk("t5_out_last", bus.out_last, 1);
    chk("t5_out_data", bus.out_data, 0);
    bus.out_ready = 1'b1;
    idle_cycle();
    bus.out_ready = 1'b0;
    chk("t5_done_valid", bus.out_valid, 0);

    // Test 6: asynchronous reset during FLUSH, then a fresh stream
    push(32'hAB, 6'd8, 1'b1);
    chk("t6_flush_valid", bus.out_valid, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", bus.out_valid, 0);
    chk("t6_async_ready", bus.in_ready, 1);
    chk("t6_async_data", bus.out_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(32'hFFFF_FFFF, 6'd4, 1'b0);
    chk("t6_mask", bus.out_data, 256'hF);
    push(32'hFFFF_FFFF, 6'd63, 1'b0);
    chk("t6_clamp_data", bus.out_data, 256'hF_FFFF_FFFF);
    chk("t6_total", bus.total_bits, 36);
    push(32'h0, 6'd0, 1'b1);
    chk("t6_tail_bits", bus.out_bits, 36);
    chk("t6_tail_last", bus.out_last, 1);
    bus.out_ready = 1'b1;
    idle_cycle();
    bus.out_ready = 1'b0;
    chk("t6_end_total", bus.total_bits, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
